// File: rtl/engine_guard.sv
`default_nettype none
// ============================================================================
// Module   : engine_guard
// Purpose  : Arm/disarm sequencer, throttle slew limiter and refresh watchdog
//            between the CPU engine registers and the four PPM generators.
// Revision : 1.0 - initial release
// ============================================================================

module engine_guard #(
    parameter int WDT_CYCLES = 1000000,
    parameter int ARM_CYCLES = 500000,
    parameter int UPD_CYCLES = 1000,
    parameter int SLEW_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WE_13,
    input  logic [31:0] WD_13,
    input  logic        WE_24,
    input  logic [31:0] WD_24,
    input  logic        CMD_WE,
    input  logic [31:0] CMD_WD,
    output logic [31:0] STATUS,
    output logic [31:0] ENG_13_OUT,
    output logic [31:0] ENG_24_OUT
);

    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int UPD_W = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;

    localparam logic [WDT_W-1:0] C_WDT_LOAD = WDT_W'(WDT_CYCLES - 1);
    localparam logic [ARM_W-1:0] C_ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
    localparam logic [UPD_W-1:0] C_UPD_LOAD = UPD_W'(UPD_CYCLES - 1);
    localparam logic [10:0]      C_STEP     = 11'(SLEW_STEP);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ARM_W-1:0]  r_arm_cnt;
    logic [WDT_W-1:0]  r_wdt_cnt;
    logic [UPD_W-1:0]  r_tick_cnt;
    logic [9:0]        r_tgt [4];
    logic [9:0]        r_cur [4];
    logic              r_sticky;
    logic [7:0]        r_fault_cnt;

    logic              w_cmd_arm;
    logic              w_cmd_disarm;
    logic              w_cmd_clear;
    logic              w_eng_we;
    logic              w_enter_armed;
    logic              w_zero;
    logic              w_fault;
    logic              w_tick;
    logic [10:0]       w_sum  [4];
    logic [9:0]        w_slew [4];
    logic              w_unused;

    // Only the highest-priority command bit is acted upon; if that command
    // is not valid in the current state, the whole write is ignored.
    assign w_cmd_disarm = CMD_WE & CMD_WD[1];
    assign w_cmd_clear  = CMD_WE & CMD_WD[2] & ~CMD_WD[1];
    assign w_cmd_arm    = CMD_WE & CMD_WD[0] & ~CMD_WD[1] & ~CMD_WD[2];
    assign w_eng_we     = WE_13 | WE_24;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DISARMED: begin
                if (w_cmd_arm) begin
                    w_state_next = ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (w_cmd_disarm) begin
                    w_state_next = ST_DISARMED;
                end else if (r_arm_cnt == '0) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_cmd_disarm) begin
                    w_state_next = ST_DISARMED;
                end else if (!w_eng_we && (r_wdt_cnt == '0)) begin
                    w_state_next = ST_FAILSAFE;
                end
            end
            ST_FAILSAFE: begin
                if (w_cmd_clear) begin
                    w_state_next = ST_DISARMED;
                end
            end
            default: w_state_next = ST_DISARMED;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_enter_armed = (r_state == ST_ARMING) && (w_state_next == ST_ARMED);
    assign w_zero        = (w_state_next == ST_DISARMED) || (w_state_next == ST_FAILSAFE);
    assign w_fault       = (r_state == ST_ARMED) && (w_state_next == ST_FAILSAFE);
    assign w_tick        = (r_tick_cnt == '0);

    // 11-bit sum keeps 1023 + step from wrapping before the clamp.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sum[i]  = {1'b0, r_cur[i]} + C_STEP;
            w_slew[i] = (w_sum[i] > {1'b0, r_tgt[i]}) ? r_tgt[i] : w_sum[i][9:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_arm_cnt   <= '0;
            r_wdt_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_sticky    <= 1'b0;
            r_fault_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_tgt[i] <= '0;
                r_cur[i] <= '0;
            end
        end else begin
            if ((r_state == ST_DISARMED) && (w_state_next == ST_ARMING)) begin
                r_arm_cnt <= C_ARM_LOAD;
            end else if ((r_state == ST_ARMING) && (r_arm_cnt != '0)) begin
                r_arm_cnt <= r_arm_cnt - ARM_W'(1);
            end

            if (w_enter_armed) begin
                r_wdt_cnt  <= C_WDT_LOAD;
                r_tick_cnt <= C_UPD_LOAD;
            end else if (r_state == ST_ARMED) begin
                if (w_eng_we) begin
                    r_wdt_cnt <= C_WDT_LOAD;
                end else if (r_wdt_cnt != '0) begin
                    r_wdt_cnt <= r_wdt_cnt - WDT_W'(1);
                end
                if (w_tick) begin
                    r_tick_cnt <= C_UPD_LOAD;
                end else begin
                    r_tick_cnt <= r_tick_cnt - UPD_W'(1);
                end
            end

            if (w_fault) begin
                r_sticky <= 1'b1;
                if (r_fault_cnt != 8'hFF) begin
                    r_fault_cnt <= r_fault_cnt + 8'd1;
                end
            end

            // Current values stay zero outside ARMED, so they drive the
            // outputs directly without any further gating.
            if (w_zero) begin
                for (int i = 0; i < 4; i++) begin
                    r_tgt[i] <= '0;
                    r_cur[i] <= '0;
                end
            end else begin
                if ((r_state == ST_ARMING) || (r_state == ST_ARMED)) begin
                    if (WE_13) begin
                        r_tgt[0] <= WD_13[9:0];
                        r_tgt[2] <= WD_13[25:16];
                    end
                    if (WE_24) begin
                        r_tgt[1] <= WD_24[9:0];
                        r_tgt[3] <= WD_24[25:16];
                    end
                end
                if (r_state == ST_ARMING) begin
                    for (int i = 0; i < 4; i++) begin
                        r_cur[i] <= '0;
                    end
                end else if (r_state == ST_ARMED) begin
                    for (int i = 0; i < 4; i++) begin
                        if (r_tgt[i] < r_cur[i]) begin
                            r_cur[i] <= r_tgt[i];
                        end else if (w_tick && (r_tgt[i] > r_cur[i])) begin
                            r_cur[i] <= w_slew[i];
                        end
                    end
                end
            end
        end
    end

    assign ENG_13_OUT = {6'b0, r_cur[2], 6'b0, r_cur[0]};
    assign ENG_24_OUT = {6'b0, r_cur[3], 6'b0, r_cur[1]};
    assign STATUS     = {16'h0, r_fault_cnt, 5'h0, r_sticky, r_state};

    assign w_unused = ^{WD_13[31:26], WD_13[15:10], WD_24[31:26], WD_24[15:10], CMD_WD[31:3]};

endmodule

`default_nettype wire

// File: tb/tb_engine_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_engine_guard
// Purpose  : Directed self-checking bench for engine_guard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_engine_guard;

    logic        CLK;
    logic        RESET;
    logic        WE_13;
    logic [31:0] WD_13;
    logic        WE_24;
    logic [31:0] WD_24;
    logic        CMD_WE;
    logic [31:0] CMD_WD;
    logic [31:0] STATUS;
    logic [31:0] ENG_13_OUT;
    logic [31:0] ENG_24_OUT;

    int n_checks = 0;
    int n_errors = 0;

    engine_guard #(
        .WDT_CYCLES (100),
        .ARM_CYCLES (10),
        .UPD_CYCLES (4),
        .SLEW_STEP  (4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WE_13      (WE_13),
        .WD_13      (WD_13),
        .WE_24      (WE_24),
        .WD_24      (WD_24),
        .CMD_WE     (CMD_WE),
        .CMD_WD     (CMD_WD),
        .STATUS     (STATUS),
        .ENG_13_OUT (ENG_13_OUT),
        .ENG_24_OUT (ENG_24_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic write13(input logic [31:0] v);
        WE_13 = 1'b1;
        WD_13 = v;
        cyc(1);
        WE_13 = 1'b0;
        WD_13 = '0;
    endtask

    task automatic cmd(input logic [31:0] v);
        CMD_WE = 1'b1;
        CMD_WD = v;
        cyc(1);
        CMD_WE = 1'b0;
        CMD_WD = '0;
    endtask

    initial begin
        int guard;
        RESET  = 1'b1;
        WE_13  = 1'b0;
        WD_13  = '0;
        WE_24  = 1'b0;
        WD_24  = '0;
        CMD_WE = 1'b0;
        CMD_WD = '0;
        cyc(2);
        RESET = 1'b0;

        // Reset state and writes ignored while disarmed
        check("rst_status", STATUS, 32'h0);
        check("rst_eng13", ENG_13_OUT, 32'h0);
        check("rst_eng24", ENG_24_OUT, 32'h0);
        write13(32'h00C8_0064);
        cyc(2);
        check("disarm_eng13", ENG_13_OUT, 32'h0);
        check("disarm_status", STATUS, 32'h0);

        // Arm, target written during ARMING, exact arming duration
        cmd(32'h1);
        check("arming_status", STATUS, 32'h1);
        write13(32'h0000_0064);
        check("arming_out0", ENG_13_OUT, 32'h0);
        cyc(8);
        check("arming_9", STATUS, 32'h1);
        cyc(1);
        check("armed_10", STATUS, 32'h2);
        check("armed_out0", ENG_13_OUT, 32'h0);

        // Ramp: one step of 4 every 4 cycles, with a refresh midway
        for (int k = 1; k <= 25; k++) begin
            if (k == 12) begin
                write13(32'h0000_0064);
                cyc(2);
            end else begin
                cyc(3);
            end
            check("ramp_hold", ENG_13_OUT, 32'(4 * (k - 1)));
            cyc(1);
            check("ramp_step", ENG_13_OUT, 32'(4 * k));
        end
        cyc(4);
        check("no_overshoot", ENG_13_OUT, 32'd100);

        // Immediate fall on the following edge
        write13(32'h0000_0014);
        check("fall_same_edge", ENG_13_OUT, 32'd100);
        cyc(1);
        check("fall_next_edge", ENG_13_OUT, 32'd20);

        // Clamp to target (22, not 24) and the 2/4 channel pair
        WE_13 = 1'b1;
        WD_13 = 32'h0000_0016;
        WE_24 = 1'b1;
        WD_24 = 32'h0003_0002;
        cyc(1);
        WE_13 = 1'b0;
        WE_24 = 1'b0;
        WD_13 = '0;
        WD_24 = '0;
        check("pre_tick_13", ENG_13_OUT, 32'd20);
        check("pre_tick_24", ENG_24_OUT, 32'h0);
        cyc(1);
        check("clamp_13", ENG_13_OUT, 32'd22);
        check("clamp_24", ENG_24_OUT, 32'h0003_0002);

        // Watchdog expiry 100 cycles after the last write
        cyc(98);
        check("wdt_99", STATUS, 32'h2);
        check("wdt_99_out", ENG_13_OUT, 32'd22);
        cyc(1);
        check("failsafe_status", STATUS, 32'h0000_0107);
        check("failsafe_eng13", ENG_13_OUT, 32'h0);
        check("failsafe_eng24", ENG_24_OUT, 32'h0);
        cmd(32'h1);
        check("failsafe_arm_ign", STATUS, 32'h0000_0107);
        cmd(32'h4);
        check("clear_sticky", STATUS, 32'h0000_0104);

        // Re-arm, then arm+disarm together -> disarm wins
        cmd(32'h1);
        check("rearm_arming", STATUS, 32'h0000_0105);
        cyc(9);
        check("rearm_9", STATUS, 32'h0000_0105);
        cyc(1);
        check("rearm_armed", STATUS, 32'h0000_0106);
        cmd(32'h3);
        check("arm_disarm", STATUS, 32'h0000_0104);

        // Write in the same cycle as expiry keeps ARMED
        cmd(32'h1);
        cyc(10);
        check("arm3_armed", STATUS, 32'h0000_0106);
        cyc(99);
        check("expiry_edge_pre", STATUS, 32'h0000_0106);
        write13(32'h0000_00C8);
        check("write_beats_wdt", STATUS, 32'h0000_0106);

        // Ramp to 40, then asynchronous reset between clock edges
        guard = 0;
        while ((ENG_13_OUT != 32'd40) && (guard < 100)) begin
            cyc(1);
            guard++;
        end
        check("ramp40_value", ENG_13_OUT, 32'd40);
        check("ramp40_cycles", 32'(guard), 32'd40);
        RESET = 1'b1;
        #1;
        check("async_rst_eng13", ENG_13_OUT, 32'h0);
        check("async_rst_eng24", ENG_24_OUT, 32'h0);
        check("async_rst_status", STATUS, 32'h0);
        cyc(1);
        RESET = 1'b0;
        cyc(2);
        check("post_rst_status", STATUS, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/engine_guard.md
# engine_guard

Safety sequencer between the CPU engine-control registers and the four `ppm_out` generators. It holds the engines at zero throttle until an explicit arm sequence completes, and limits the rate at which throttle may rise. A watchdog drops all engines to zero (FAILSAFE) if the CPU stops refreshing throttle. It replaces the direct `io32` → `ppm_out` path; the bus controller drives its write strobes and reads its status word.

## Interface
Parameters:
- `WDT_CYCLES`, 1000000: CLK cycles without an engine write before FAILSAFE.
- `ARM_CYCLES`, 500000: CLK cycles spent in ARMING at zero output.
- `UPD_CYCLES`, 1000: CLK cycles between slew updates.
- `SLEW_STEP`, 4: maximum throttle increase per channel per slew update (10-bit units).

Ports:
- `CLK`  in  1  CPU clock (CLK_CPU).
- `RESET`  in  1  asynchronous, active-high reset.
- `WE_13`  in  1  write strobe, engines 1/3 target.
- `WD_13`  in  32  [9:0] engine 1 target, [25:16] engine 3 target.
- `WE_24`  in  1  write strobe, engines 2/4 target.
- `WD_24`  in  32  [9:0] engine 2 target, [25:16] engine 4 target.
- `CMD_WE`  in  1  command strobe.
- `CMD_WD`  in  32  bit0 arm, bit1 disarm, bit2 clear-failsafe.
- `STATUS`  out  32  [1:0] state, [2] sticky failsafe flag, [15:8] saturating fault count; other bits 0.
- `ENG_13_OUT`  out  32  engine 1 in [9:0], engine 3 in [25:16]; other bits 0.
- `ENG_24_OUT`  out  32  engine 2 in [9:0], engine 4 in [25:16]; other bits 0.

## Operation
- **State encoding:** DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.
- **Reset values:** state DISARMED; all targets, current values, counters, the sticky flag and the fault count are 0; all outputs 0.
- **Command priority** within one `CMD_WE`: disarm > clear > arm. Commands not valid in the current state are ignored.
- **DISARMED:**
  - Outputs 0; engine writes are ignored.
  - Arm → ARMING, with the arm counter loaded to `ARM_CYCLES`-1.
- **ARMING:**
  - Outputs 0; engine writes update the targets.
  - The arm counter decrements each cycle. At 0 → ARMED: current values = 0, watchdog loaded to `WDT_CYCLES`-1, slew tick counter restarted.
  - Disarm → DISARMED.
- **ARMED:**
  - Any `WE_13` or `WE_24` reloads the watchdog; otherwise it decrements.
  - Watchdog reaching 0 with no write that cycle → FAILSAFE; set the sticky flag; increment the fault count, saturating at 255.
  - Disarm → DISARMED.
- **Slew rule in ARMED, per channel:**
  - If target < current: current = target (falls are immediate).
  - On each slew tick (every `UPD_CYCLES` cycles), if target > current: current = min(target, current + `SLEW_STEP`).
  - Arithmetic uses 11 bits, so 1023 + step cannot wrap.
- **FAILSAFE:**
  - Outputs 0; engine writes are ignored; arm is ignored.
  - Clear → DISARMED. The sticky flag is unaffected by clear; only `RESET` clears it.
- **Entering DISARMED or FAILSAFE** zeroes all targets and current values, so re-arming always starts from 0.
- **Outputs:** current values packed as above in ARMED; 0 in every other state.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- **Command latency:** `CMD_WE` at edge n → new state and `STATUS` visible after edge n.
- **Engine write path:**
  - Write at edge n → target updated at edge n.
  - A fall is reflected in the output at edge n+1.
  - A rise is applied at the first slew tick after edge n.
- **Write vs. expiry:** a write in the same cycle as watchdog expiry wins; the watchdog reloads and the state stays ARMED.
- **FAILSAFE and disarm:** outputs are 0 at the same edge the state changes.
- **Asynchronous reset:** `RESET` asserted mid-operation forces all reset values immediately, without waiting for a clock edge.
- **ARMING duration:** exactly `ARM_CYCLES` cycles from the arm edge to the ARMED edge.

## Test plan
Bench parameters: `WDT_CYCLES`=100, `ARM_CYCLES`=10, `UPD_CYCLES`=4, `SLEW_STEP`=4.

1. Reset, then write `WD_13`=0x00C8_0064 while DISARMED → outputs stay 0; `STATUS`=0.
2. Arm, write `WD_13`=0x0000_0064 during ARMING → state=2 exactly 10 cycles after arm; engine 1 output rises 4, 8, …, 100, one step per 4 cycles; no overshoot.
3. In ARMED at output 100, write target 20 → output 20 on the next cycle.
4. Stop writing in ARMED → FAILSAFE at cycle 100; outputs 0; `STATUS`=0x0000_0107. Arm is ignored; clear → state 0 with the sticky flag still set.
5. Issue a `CMD_WD`=0x3 command with arm+disarm in ARMED → DISARMED. Write at the same cycle as watchdog expiry → stays ARMED.
6. Assert `RESET` mid-slew with output at 40 → outputs 0 immediately; `STATUS`=0; fault count cleared.
